// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write arbiter: register index, buffered
// long-latency result entry and grant source.
package rf_arb_pkg;

    localparam int DATA_W    = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t            rd;
        logic [DATA_W-1:0]   data;
    } ll_entry_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WB,
        GNT_LL
    } gnt_src_e;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Decode/writeback/long-latency/register-file signal bundle for rf_write_arbiter.
// Bypass outputs exist only when RFARB_BYPASS_EN is defined.
interface rf_write_arbiter_if #(
    parameter int XLEN = 32
);
    import rf_arb_pkg::*;

    logic             issue_valid;
    reg_idx_t         issue_rd;
    reg_idx_t         dec_rs1;
    reg_idx_t         dec_rs2;
    logic             hazard;
    logic             wb_valid;
    reg_idx_t         wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             wb_ready;
    logic             ll_valid;
    reg_idx_t         ll_rd;
    logic [XLEN-1:0]  ll_data;
    logic             ll_ready;
    logic             rf_we;
    reg_idx_t         rf_rd;
    logic [XLEN-1:0]  rf_din;
`ifdef RFARB_BYPASS_EN
    logic             byp1_hit;
    logic             byp2_hit;
    logic [XLEN-1:0]  byp1_data;
    logic [XLEN-1:0]  byp2_data;
`endif

    modport master (
        output issue_valid, issue_rd, dec_rs1, dec_rs2,
               wb_valid, wb_rd, wb_data, ll_valid, ll_rd, ll_data,
        input  hazard, wb_ready, ll_ready, rf_we, rf_rd, rf_din
`ifdef RFARB_BYPASS_EN
        , input byp1_hit, byp2_hit, byp1_data, byp2_data
`endif
    );

    modport slave (
        input  issue_valid, issue_rd, dec_rs1, dec_rs2,
               wb_valid, wb_rd, wb_data, ll_valid, ll_rd, ll_data,
        output hazard, wb_ready, ll_ready, rf_we, rf_rd, rf_din
`ifdef RFARB_BYPASS_EN
        , output byp1_hit, byp2_hit, byp1_data, byp2_data
`endif
    );

endinterface

// File: rtl/rf_arb_fifo.sv
// Power-of-two circular buffer of long-latency results. With RFARB_BYPASS_EN it
// also exposes every entry in age order (index 0 = oldest) for forwarding.
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  ll_entry_t  entry_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output ll_entry_t  head_o
`ifdef RFARB_BYPASS_EN
    ,
    output ll_entry_t [DEPTH-1:0] entries_o,
    output logic      [DEPTH-1:0] valid_o
`endif
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    ll_entry_t [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [PTR_W:0]        count_q;
    logic                  push_ok;
    logic                  pop_ok;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= entry_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + 1'b1;
            end else if (!push_ok && pop_ok) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

`ifdef RFARB_BYPASS_EN
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_o[i] = mem_q[rd_ptr_q + PTR_W'(i)];
            valid_o[i]   = ((PTR_W+1)'(i) < count_q);
        end
    end
`endif

endmodule

// File: rtl/rf_write_arbiter.sv
// Single register-file write port shared by pipeline writeback (priority) and a
// buffered long-latency unit, with pending scoreboard; RFARB_BYPASS_EN adds forwarding.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int XLEN         = DATA_W,
    parameter int NREG         = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    rf_write_arbiter_if.slave  bus
);
    localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);

    logic [NREG-1:0]    pending_q, pending_d;
    logic [SCNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic               stall_q, stall_d;
    gnt_src_e           gnt;
    logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic               head_blocked;
    ll_entry_t          fifo_head, ll_in;
    reg_idx_t           rf_rd;
    logic [XLEN-1:0]    rf_din;
    logic               rs1_pend, rs2_pend;
`ifdef RFARB_BYPASS_EN
    ll_entry_t [FIFO_DEPTH-1:0] fifo_entries;
    logic      [FIFO_DEPTH-1:0] fifo_valid;
`endif

    assign ll_in     = '{rd: bus.ll_rd, data: bus.ll_data};
    assign fifo_push = bus.ll_valid && !fifo_full;
    assign fifo_pop  = (gnt == GNT_LL);

    rf_arb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (fifo_push),
        .entry_i   (ll_in),
        .pop_i     (fifo_pop),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .head_o    (fifo_head)
`ifdef RFARB_BYPASS_EN
        ,
        .entries_o (fifo_entries),
        .valid_o   (fifo_valid)
`endif
    );

    always_comb begin
        gnt = GNT_NONE;
        if (stall_q) begin
            if (!fifo_empty) gnt = GNT_LL;
        end else if (bus.wb_valid) begin
            gnt = GNT_WB;
        end else if (!fifo_empty) begin
            gnt = GNT_LL;
        end
    end

    always_comb begin
        rf_rd  = '0;
        rf_din = '0;
        unique case (gnt)
            GNT_WB: begin
                rf_rd  = bus.wb_rd;
                rf_din = bus.wb_data;
            end
            GNT_LL: begin
                rf_rd  = fifo_head.rd;
                rf_din = fifo_head.data;
            end
            default: ;
        endcase
    end

    // x0 is never written; reset also masks any write decided from stale state.
    assign bus.rf_we    = (gnt != GNT_NONE) && (rf_rd != '0) && !reset;
    assign bus.rf_rd    = rf_rd;
    assign bus.rf_din   = rf_din;
    assign bus.wb_ready = !stall_q;
    assign bus.ll_ready = !fifo_full;

    always_comb begin
        rs1_pend = pending_q[bus.dec_rs1];
        rs2_pend = pending_q[bus.dec_rs2];
`ifdef RFARB_BYPASS_EN
        bus.byp1_hit  = 1'b0;
        bus.byp2_hit  = 1'b0;
        bus.byp1_data = '0;
        bus.byp2_data = '0;
        // Later (younger) matches override earlier ones.
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_valid[i] && bus.dec_rs1 != '0 && fifo_entries[i].rd == bus.dec_rs1) begin
                bus.byp1_hit  = 1'b1;
                bus.byp1_data = fifo_entries[i].data;
            end
            if (fifo_valid[i] && bus.dec_rs2 != '0 && fifo_entries[i].rd == bus.dec_rs2) begin
                bus.byp2_hit  = 1'b1;
                bus.byp2_data = fifo_entries[i].data;
            end
        end
        if (bus.byp1_hit) rs1_pend = 1'b0;
        if (bus.byp2_hit) rs2_pend = 1'b0;
`endif
        bus.hazard = rs1_pend | rs2_pend | (bus.issue_valid & pending_q[bus.issue_rd]);
    end

    always_comb begin
        pending_d = pending_q;
        if (fifo_pop) pending_d[fifo_head.rd] = 1'b0;
        if (bus.issue_valid && bus.issue_rd != '0) pending_d[bus.issue_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    assign head_blocked = bus.wb_valid && !stall_q && !fifo_empty;

    always_comb begin
        starve_cnt_d = '0;
        stall_d      = 1'b0;
        if (fifo_full && head_blocked) begin
            if (starve_cnt_q == SCNT_W'(STARVE_LIMIT - 1)) begin
                stall_d = 1'b1;
            end else begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q    <= '0;
            starve_cnt_q <= '0;
            stall_q      <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            starve_cnt_q <= starve_cnt_d;
            stall_q      <= stall_d;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized bench for rf_write_arbiter against a queue-based reference model.
// Bypass outputs are also checked when RFARB_BYPASS_EN is defined.
module tb_rf_write_arbiter;
    import rf_arb_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;
    localparam int NCYC  = 2000;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } m_entry_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rf_write_arbiter_if #(.XLEN(XLEN)) bus ();

    rf_write_arbiter #(
        .XLEN(XLEN), .NREG(NREG), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    m_entry_t mq[$];
    bit       m_pend[NREG];
    int       m_scnt;
    bit       m_stall;
    int       n_tests = 0;
    int       n_fail  = 0;

    task automatic chk_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // 0 = idle, 1 = writeback, 2 = long-latency drain
    function automatic int model_grant();
        if (m_stall) return (mq.size() == 0) ? 0 : 2;
        if (bus.wb_valid) return 1;
        return (mq.size() == 0) ? 0 : 2;
    endfunction

    function automatic bit model_byp(input logic [4:0] rs, output logic [31:0] d);
        d = '0;
        if (rs == 5'd0) return 1'b0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].rd == rs) begin
                d = mq[i].data;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic bit model_hazard(logic [4:0] rs1, logic [4:0] rs2, bit iv, logic [4:0] ird);
        bit p1 = m_pend[rs1];
        bit p2 = m_pend[rs2];
`ifdef RFARB_BYPASS_EN
        logic [31:0] d;
        if (model_byp(rs1, d)) p1 = 1'b0;
        if (model_byp(rs2, d)) p2 = 1'b0;
`endif
        return p1 | p2 | (iv & m_pend[ird]);
    endfunction

    task automatic check_outputs();
        int          g     = model_grant();
        bit          e_we;
        logic [4:0]  e_rd  = 5'd0;
        logic [31:0] e_din = 32'd0;
`ifdef RFARB_BYPASS_EN
        bit          h;
        logic [31:0] d;
`endif
        if (g == 1) begin
            e_rd  = bus.wb_rd;
            e_din = bus.wb_data;
        end else if (g == 2) begin
            e_rd  = mq[0].rd;
            e_din = mq[0].data;
        end
        e_we = (g != 0) && (e_rd != 5'd0) && !reset;
        chk_eq("hazard",   bus.hazard,   model_hazard(bus.dec_rs1, bus.dec_rs2, bus.issue_valid, bus.issue_rd));
        chk_eq("wb_ready", bus.wb_ready, !m_stall);
        chk_eq("ll_ready", bus.ll_ready, mq.size() != DEPTH);
        chk_eq("rf_we",    bus.rf_we,    e_we);
        if (e_we) begin
            chk_eq("rf_rd",  bus.rf_rd,  e_rd);
            chk_eq("rf_din", bus.rf_din, e_din);
        end
`ifdef RFARB_BYPASS_EN
        h = model_byp(bus.dec_rs1, d);
        chk_eq("byp1_hit", bus.byp1_hit, h);
        if (h) chk_eq("byp1_data", bus.byp1_data, d);
        h = model_byp(bus.dec_rs2, d);
        chk_eq("byp2_hit", bus.byp2_hit, h);
        if (h) chk_eq("byp2_data", bus.byp2_data, d);
`endif
    endtask

    task automatic model_step();
        bit       full    = (mq.size() == DEPTH);
        int       g       = model_grant();
        bit       blocked = full && bus.wb_valid && !m_stall;
        m_entry_t e;
        if (reset) begin
            mq.delete();
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_scnt  = 0;
            m_stall = 1'b0;
            return;
        end
        if (g == 2) begin
            e = mq.pop_front();
            m_pend[e.rd] = 1'b0;
        end
        if (bus.ll_valid && !full) begin
            e.rd   = bus.ll_rd;
            e.data = bus.ll_data;
            mq.push_back(e);
        end
        if (bus.issue_valid && bus.issue_rd != 5'd0) m_pend[bus.issue_rd] = 1'b1;
        if (blocked) begin
            m_scnt++;
            m_stall = (m_scnt >= LIMIT);
            if (m_stall) m_scnt = 0;
        end else begin
            m_scnt  = 0;
            m_stall = 1'b0;
        end
    endtask

    // Phase shapes traffic: mixed, writeback-saturated (starvation), drain-heavy.
    task automatic drive(int cyc, bit hold_wb);
        int phase   = (cyc / 100) % 4;
        int wb_pct  = (phase == 1) ? 95 : (phase == 2) ? 15 : 50;
        int ll_pct  = (phase == 1) ? 90 : 50;
        reset           = (cyc % 337 == 336);
        bus.dec_rs1     = 5'($urandom_range(0, 7));
        bus.dec_rs2     = 5'($urandom_range(0, 7));
        bus.issue_rd    = 5'($urandom_range(0, 7));
        bus.issue_valid = ($urandom_range(0, 99) < 30);
        if (model_hazard(bus.dec_rs1, bus.dec_rs2, 1'b1, bus.issue_rd)) bus.issue_valid = 1'b0;
        if (!hold_wb) begin
            bus.wb_valid = ($urandom_range(0, 99) < wb_pct);
            bus.wb_rd    = 5'($urandom_range(0, 7));
            bus.wb_data  = $urandom;
        end
        bus.ll_valid = ($urandom_range(0, 99) < ll_pct);
        bus.ll_rd    = 5'($urandom_range(0, 7));
        bus.ll_data  = $urandom;
    endtask

    initial begin
        bit hold_wb = 1'b0;
        reset           = 1'b1;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.dec_rs1     = '0;
        bus.dec_rs2     = '0;
        bus.wb_valid    = 1'b0;
        bus.wb_rd       = '0;
        bus.wb_data     = '0;
        bus.ll_valid    = 1'b0;
        bus.ll_rd       = '0;
        bus.ll_data     = '0;
        m_scnt          = 0;
        m_stall         = 1'b0;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_eq("rst_rf_we",    bus.rf_we,    1'b0);
        chk_eq("rst_hazard",   bus.hazard,   1'b0);
        chk_eq("rst_wb_ready", bus.wb_ready, 1'b1);
        chk_eq("rst_ll_ready", bus.ll_ready, 1'b1);
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            drive(cyc, hold_wb);
            #1;
            check_outputs();
            @(posedge clk);
            hold_wb = bus.wb_valid && m_stall && !reset;
            model_step();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
